// File: rtl/riscv_rf_pkg.sv
// Shared register-file constants and types for the writeback scheduler.
package riscv_rf_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned NUM_REGS  = 32;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xword_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr, and ptr moves past the winner on each grant.
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_o,
    output logic                 gnt_valid_o,
    output logic [$clog2(N)-1:0] gnt_idx_o
);

    localparam int unsigned PtrW = $clog2(N);

    logic [PtrW-1:0] ptr_q, ptr_d;
    int              cand;

    always_comb begin
        gnt_o       = '0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        ptr_d       = ptr_q;
        cand        = 0;
        if (!reset) begin
            for (int k = 0; k < int'(N); k++) begin
                cand = (int'(ptr_q) + k) % int'(N);
                if (!gnt_valid_o && req_i[cand]) begin
                    gnt_valid_o = 1'b1;
                    gnt_o[cand] = 1'b1;
                    gnt_idx_o   = PtrW'(cand);
                    ptr_d       = PtrW'((cand + 1) % int'(N));
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Arbitrates writeback sources onto the single regfile write port and tracks per-register
// pending writes so decode can stall RAW/WAW hazards.
module regfile_wb_scheduler
    import riscv_rf_pkg::*;
#(
    parameter int unsigned NUM_WB    = 3,
    parameter int unsigned XLEN      = riscv_rf_pkg::XLEN,
    parameter int unsigned REG_IDX_W = riscv_rf_pkg::REG_IDX_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_WB-1:0]             wb_req,
    input  logic [NUM_WB*REG_IDX_W-1:0]   wb_idx,
    input  logic [NUM_WB*XLEN-1:0]        wb_data,
    output logic [NUM_WB-1:0]             wb_gnt,
    output logic                          rf_wr_en,
    output logic [REG_IDX_W-1:0]          rf_wr_idx,
    output logic [XLEN-1:0]               rf_wr_data,
    input  logic                          issue_valid,
    input  logic [REG_IDX_W-1:0]          issue_rd,
    output logic                          issue_ready,
    input  logic [REG_IDX_W-1:0]          rs1_idx,
    input  logic [REG_IDX_W-1:0]          rs2_idx,
    output logic                          rs1_busy,
    output logic                          rs2_busy
);

    localparam int unsigned NumRegs = 1 << REG_IDX_W;
    localparam int unsigned PtrW    = $clog2(NUM_WB);

    logic                 gnt_valid;
    logic [PtrW-1:0]      gnt_idx;
    logic [REG_IDX_W-1:0] sel_idx;
    logic [XLEN-1:0]      sel_data;

    logic                 wr_en_q, wr_en_d;
    logic [REG_IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [XLEN-1:0]      wr_data_q, wr_data_d;
    logic [NumRegs-1:0]   busy_q, busy_d;
    logic                 issue_fire;

    rr_arbiter #(
        .N (NUM_WB)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req_i       (wb_req),
        .gnt_o       (wb_gnt),
        .gnt_valid_o (gnt_valid),
        .gnt_idx_o   (gnt_idx)
    );

    always_comb begin
        sel_idx  = wb_idx[int'(gnt_idx)*REG_IDX_W +: REG_IDX_W];
        sel_data = wb_data[int'(gnt_idx)*XLEN +: XLEN];
    end

    // Idle cycles hold index/data so the regfile bus does not toggle needlessly.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_idx_d  = wr_idx_q;
        wr_data_d = wr_data_q;
        if (gnt_valid) begin
            wr_en_d   = (sel_idx != '0);
            wr_idx_d  = sel_idx;
            wr_data_d = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign issue_ready = ~busy_q[issue_rd];
    assign issue_fire  = issue_valid & issue_ready & (issue_rd != '0);

    // Clear applied first so a same-index issue on the commit edge keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_en_q) begin
            busy_d[wr_idx_q] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs1_busy   = busy_q[rs1_idx];
    assign rs2_busy   = busy_q[rs2_idx];
    assign rf_wr_en   = wr_en_q;
    assign rf_wr_idx  = wr_idx_q;
    assign rf_wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Scoreboard bench: expected regfile writes are queued at grant time and popped by a monitor.
`timescale 1ns/1ps
module tb_regfile_wb_scheduler;

    localparam int unsigned NumWb = 3;
    localparam int unsigned Xlen  = 32;
    localparam int unsigned IdxW  = 5;

    logic                   clk;
    logic                   reset;
    logic [NumWb-1:0]       wb_req;
    logic [NumWb*IdxW-1:0]  wb_idx;
    logic [NumWb*Xlen-1:0]  wb_data;
    logic [NumWb-1:0]       wb_gnt;
    logic                   rf_wr_en;
    logic [IdxW-1:0]        rf_wr_idx;
    logic [Xlen-1:0]        rf_wr_data;
    logic                   issue_valid;
    logic [IdxW-1:0]        issue_rd;
    logic                   issue_ready;
    logic [IdxW-1:0]        rs1_idx;
    logic [IdxW-1:0]        rs2_idx;
    logic                   rs1_busy;
    logic                   rs2_busy;

    typedef struct packed {
        logic [IdxW-1:0] idx;
        logic [Xlen-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    regfile_wb_scheduler #(
        .NUM_WB    (NumWb),
        .XLEN      (Xlen),
        .REG_IDX_W (IdxW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_req      (wb_req),
        .wb_idx      (wb_idx),
        .wb_data     (wb_data),
        .wb_gnt      (wb_gnt),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_idx   (rf_wr_idx),
        .rf_wr_data  (rf_wr_data),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1_idx     (rs1_idx),
        .rs2_idx     (rs2_idx),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [IdxW-1:0] idx, input logic [Xlen-1:0] d);
        wb_idx[s*IdxW +: IdxW] = idx;
        wb_data[s*Xlen +: Xlen] = d;
    endtask

    task automatic expect_wr(input logic [IdxW-1:0] idx, input logic [Xlen-1:0] d);
        wr_t e;
        e.idx  = idx;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every regfile write must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_idx", 32'(rf_wr_idx), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_idx", 32'(rf_wr_idx), 32'(e.idx));
                chk("wr_data", rf_wr_data, e.data);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        wb_req      = 3'b111;
        wb_idx      = '0;
        wb_data     = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1_idx     = 5'd5;
        rs2_idx     = 5'd9;
        set_src(0, 5'd5, 32'hA000_0000);
        set_src(1, 5'd6, 32'hA000_0001);
        set_src(2, 5'd7, 32'hA000_0002);

        // Reset with requests pending
        repeat (2) begin
            @(negedge clk);
            chk("rst_gnt", 32'(wb_gnt), 32'd0);
            chk("rst_wr_en", 32'(rf_wr_en), 32'd0);
            chk("rst_rs1_busy", 32'(rs1_busy), 32'd0);
            chk("rst_rs2_busy", 32'(rs2_busy), 32'd0);
            tick();
        end
        reset = 1'b0;

        // Round robin with all requests held
        for (int g = 0; g < 4; g++) begin
            int s;
            s = g % 3;
            @(negedge clk);
            chk("rr_gnt", 32'(wb_gnt), 32'(1 << s));
            expect_wr(5'(5 + s), 32'hA000_0000 + 32'(s));
            tick();
        end
        wb_req = 3'b000;

        // Scoreboard set / clear on rd=9
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        rs1_idx     = 5'd9;
        @(negedge clk);
        chk("sb_issue_ready", 32'(issue_ready), 32'd1);
        chk("sb_same_cycle", 32'(rs1_busy), 32'd0);
        tick();
        @(negedge clk);
        chk("sb_busy_set", 32'(rs1_busy), 32'd1);
        chk("sb_waw_stall", 32'(issue_ready), 32'd0);
        tick();
        issue_valid = 1'b0;
        wb_req      = 3'b010;
        set_src(1, 5'd9, 32'hB900_0009);
        @(negedge clk);
        chk("sb_gnt", 32'(wb_gnt), 32'b010);
        expect_wr(5'd9, 32'hB900_0009);
        chk("sb_busy_t", 32'(rs1_busy), 32'd1);
        tick();
        wb_req = 3'b000;
        @(negedge clk);
        chk("sb_busy_t1", 32'(rs1_busy), 32'd1);
        tick();
        rs2_idx = 5'd9;
        @(negedge clk);
        chk("sb_busy_t2", 32'(rs1_busy), 32'd0);
        chk("sb_busy_t2_rs2", 32'(rs2_busy), 32'd0);
        tick();

        // x0 handling
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        @(negedge clk);
        chk("x0_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        rs1_idx     = 5'd0;
        rs2_idx     = 5'd0;
        wb_req      = 3'b100;
        set_src(2, 5'd0, 32'hC000_0000);
        @(negedge clk);
        chk("x0_rs1_busy", 32'(rs1_busy), 32'd0);
        chk("x0_rs2_busy", 32'(rs2_busy), 32'd0);
        chk("x0_gnt", 32'(wb_gnt), 32'b100);
        tick();
        wb_req = 3'b000;
        @(negedge clk);
        chk("x0_no_write", 32'(rf_wr_en), 32'd0);
        tick();

        // Set/clear collision on rd=12
        issue_valid = 1'b1;
        issue_rd    = 5'd12;
        rs1_idx     = 5'd12;
        @(negedge clk);
        chk("col_first_issue", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        wb_req      = 3'b001;
        set_src(0, 5'd12, 32'hD100_0012);
        @(negedge clk);
        chk("col_gnt0", 32'(wb_gnt), 32'b001);
        expect_wr(5'd12, 32'hD100_0012);
        chk("col_busy", 32'(rs1_busy), 32'd1);
        tick();
        wb_req      = 3'b000;
        issue_valid = 1'b1;
        @(negedge clk);
        chk("col_commit_cycle_stall", 32'(issue_ready), 32'd0);
        tick();
        issue_valid = 1'b0;
        wb_req      = 3'b010;
        set_src(1, 5'd12, 32'hD200_0012);
        @(negedge clk);
        chk("col_cleared", 32'(rs1_busy), 32'd0);
        chk("col_gnt1", 32'(wb_gnt), 32'b010);
        expect_wr(5'd12, 32'hD200_0012);
        tick();
        wb_req      = 3'b000;
        issue_valid = 1'b1;
        @(negedge clk);
        chk("col_ready", 32'(issue_ready), 32'd1);
        chk("col_wr_en", 32'(rf_wr_en), 32'd1);
        tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("col_set_wins", 32'(rs1_busy), 32'd1);
        tick();

        // Reset mid-operation
        issue_valid = 1'b1;
        issue_rd    = 5'd20;
        rs1_idx     = 5'd20;
        rs2_idx     = 5'd12;
        wb_req      = 3'b111;
        set_src(0, 5'd5, 32'hE000_0000);
        set_src(1, 5'd6, 32'hE000_0001);
        set_src(2, 5'd7, 32'hE000_0002);
        @(negedge clk);
        chk("mid_gnt", 32'(wb_gnt), 32'b100);
        chk("mid_ready", 32'(issue_ready), 32'd1);
        expect_wr(5'd7, 32'hE000_0002);
        tick();
        issue_valid = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        chk("mid_rst_gnt", 32'(wb_gnt), 32'd0);
        chk("mid_busy_before", 32'(rs1_busy), 32'd1);
        chk("mid_wr_en_before", 32'(rf_wr_en), 32'd1);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid_wr_en_after", 32'(rf_wr_en), 32'd0);
        chk("mid_busy20_clr", 32'(rs1_busy), 32'd0);
        chk("mid_busy12_clr", 32'(rs2_busy), 32'd0);
        chk("mid_ptr_reset", 32'(wb_gnt), 32'b001);
        expect_wr(5'd5, 32'hE000_0000);
        tick();
        wb_req = 3'b000;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
